// File: rtl/digit_scan_ctrl.sv
// Round-robin seven-segment scan controller: grants the shared cathode bus to enabled
// digits in turn, with a blanking interval before each drive interval.
module digit_scan_ctrl #(
    parameter int SLOT_CYCLES  = 4096,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] en_i,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    output logic [3:0] an_o,
    output logic [6:0] seg_o,
    output logic [1:0] active_o,
    output logic       frame_o
);

    // state  | meaning
    // IDLE   | no digit enabled, bus dark
    // BLANK  | slot granted, anodes/segments held off
    // DRIVE  | anode of ptr low, segments show held value
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [3:0]    held_q, held_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_q, frame_d;

    logic          gnt_valid;
    logic [1:0]    gnt_idx;
    logic [1:0]    cand;
    logic [3:0]    gnt_digit;
    logic          do_grant;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Scan from farthest to nearest so the first enabled digit after ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr_q + k[1:0];
            if (en_i[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        case (gnt_idx)
            2'd0:    gnt_digit = digit0_i;
            2'd1:    gnt_digit = digit1_i;
            2'd2:    gnt_digit = digit2_i;
            default: gnt_digit = digit3_i;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        held_d   = held_q;
        cnt_d    = cnt_q;
        frame_d  = 1'b0;
        do_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) do_grant = 1'b1;
            end
            ST_BLANK: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (!en_i[ptr_q] || (cnt_q == SLOT_LAST)) begin
                    if (gnt_valid) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_grant) begin
            ptr_d   = gnt_idx;
            held_d  = gnt_digit;
            cnt_d   = '0;
            state_d = ST_BLANK;
            frame_d = (gnt_idx <= ptr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd3;
            held_q  <= 4'd0;
            cnt_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end

    assign an_o     = (state_q == ST_DRIVE) ? ~(4'b0001 << ptr_q) : 4'b1111;
    assign seg_o    = (state_q == ST_DRIVE) ? hex7(held_q) : 7'b1111111;
    assign active_o = ptr_q;
    assign frame_o  = frame_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with an 8-cycle slot and 2-cycle blank.
module tb_digit_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] en;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] active;
    logic       frame;

    int n_cmp = 0;
    int n_err = 0;

    digit_scan_ctrl #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .digit0_i(d0), .digit1_i(d1), .digit2_i(d2), .digit3_i(d3),
        .an_o(an), .seg_o(seg), .active_o(active), .frame_o(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Checks ncyc cycles of a slot owned by digit d, starting from its first blank cycle.
    task automatic check_slot(input logic [1:0] d, input logic [6:0] seg_exp,
                              input logic fr_exp, input int ncyc);
        logic [3:0] an_drv;
        an_drv = ~(4'b0001 << d);
        for (int p = 0; p < ncyc; p++) begin
            @(negedge clk);
            chk("active", 32'(active), 32'(d));
            chk("frame", 32'(frame), (p == 0) ? 32'(fr_exp) : 32'd0);
            if (p < 2) begin
                chk("an_blank", 32'(an), 32'hF);
                chk("seg_blank", 32'(seg), 32'h7F);
            end else begin
                chk("an_drive", 32'(an), 32'(an_drv));
                chk("seg_drive", 32'(seg), 32'(seg_exp));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 4'b1111;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_active", 32'(active), 32'd3);
        chk("rst_frame", 32'(frame), 32'd0);
        rst_n = 1'b1;

        // All four digits, full rotation plus wrap back to digit0.
        check_slot(2'd0, 7'b1111001, 1'b1, 8);
        check_slot(2'd1, 7'b0100100, 1'b0, 8);
        check_slot(2'd2, 7'b0110000, 1'b0, 8);
        check_slot(2'd3, 7'b0011001, 1'b0, 8);
        check_slot(2'd0, 7'b1111001, 1'b1, 8);

        // Digits 0 and 2 only.
        en = 4'b0101;
        check_slot(2'd2, 7'b0110000, 1'b0, 8);
        check_slot(2'd0, 7'b1111001, 1'b1, 8);
        check_slot(2'd2, 7'b0110000, 1'b0, 8);
        check_slot(2'd0, 7'b1111001, 1'b1, 8);

        // Value change on the owning digit mid-slot is held off until its next grant.
        en = 4'b1111;
        d1 = 4'd3;
        fork
            check_slot(2'd1, 7'b0110000, 1'b0, 8);
            begin
                repeat (3) @(negedge clk);
                d1 = 4'd8;
            end
        join
        check_slot(2'd2, 7'b0110000, 1'b0, 8);
        check_slot(2'd3, 7'b0011001, 1'b0, 8);
        check_slot(2'd0, 7'b1111001, 1'b1, 8);
        check_slot(2'd1, 7'b0000000, 1'b0, 8);

        // Digit2 disabled on its third drive cycle: slot truncated, digit3 next.
        check_slot(2'd2, 7'b0110000, 1'b0, 5);
        en = 4'b1011;
        check_slot(2'd3, 7'b0011001, 1'b0, 8);
        check_slot(2'd0, 7'b1111001, 1'b1, 8);
        check_slot(2'd1, 7'b0000000, 1'b0, 8);
        check_slot(2'd3, 7'b0011001, 1'b0, 8);

        // Reset mid-drive forces the bus dark without a clock edge.
        check_slot(2'd0, 7'b1111001, 1'b1, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_active", 32'(active), 32'd3);
        chk("arst_frame", 32'(frame), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_slot(2'd0, 7'b1111001, 1'b1, 8);

        // Nothing enabled after reset: stays idle.
        #2 rst_n = 1'b0;
        en = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_an", 32'(an), 32'hF);
            chk("idle_seg", 32'(seg), 32'h7F);
            chk("idle_frame", 32'(frame), 32'd0);
            chk("idle_active", 32'(active), 32'd3);
        end

        // Single enabled digit is re-granted every slot with a frame pulse each time.
        en = 4'b1000;
        check_slot(2'd3, 7'b0011001, 1'b1, 8);
        check_slot(2'd3, 7'b0011001, 1'b1, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
